// File: rtl/hms_param_clock_if.sv
// Control/display bundle for the parameterised HH:MM:SS clock.
// The master side drives the buttons and preload bus; the slave side drives the display.
interface hms_param_clock_if;
  logic       ss;
  logic       sel;
  logic       inc;
  logic       dec;
  logic       load;
  logic [2:0] addr;
  logic [5:0] din;
  logic       fmt12;
  logic [4:0] hrs;
  logic       pm;
  logic [5:0] min;
  logic [5:0] sec;
  logic       alarm;
  logic [2:0] mode;

  modport master (
    output ss, sel, inc, dec, load, addr, din, fmt12,
    input  hrs, pm, min, sec, alarm, mode
  );

  modport slave (
    input  ss, sel, inc, dec, load, addr, din, fmt12,
    output hrs, pm, min, sec, alarm, mode
  );
endinterface

// File: rtl/hms_param_clock.sv
// 24-hour time-of-day clock with run/preload/edit modes, sticky alarm and 12 h display option.
// Time is always kept internally as 0..23 hours; fmt12 only reshapes the outputs.
module hms_param_clock #(
  parameter int TICK_DIV = 5,
  parameter int ALARM_EN = 1
) (
  input logic              clk,
  input logic              rst,
  hms_param_clock_if.slave bus
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    RUN = 3'd0, PL = 3'd1, HB = 3'd2, MB = 3'd3, SB = 3'd4, AH = 3'd5, AM = 3'd6
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [4:0]       hrs_q, hrs_n, ahrs_q, ahrs_n;
  logic [5:0]       min_q, min_n, sec_q, sec_n, amin_q, amin_n;
  logic             alarm_q, alarm_n;
  logic             tick;
  logic [4:0]       hrs_disp;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec60(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v >= 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] dec24(input logic [4:0] v);
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      RUN: if (bus.ss) state_n = PL;
      PL: begin
        if (bus.ss)       state_n = RUN;
        else if (bus.sel) state_n = HB;
      end
      HB: begin
        if (bus.sel)     state_n = MB;
        else if (bus.ss) state_n = RUN;
      end
      MB: begin
        if (bus.sel)     state_n = SB;
        else if (bus.ss) state_n = RUN;
      end
      SB: begin
        if (bus.sel)     state_n = (ALARM_EN != 0) ? AH : HB;
        else if (bus.ss) state_n = RUN;
      end
      AH: begin
        if (bus.sel)     state_n = AM;
        else if (bus.ss) state_n = RUN;
      end
      AM: begin
        if (bus.sel)     state_n = HB;
        else if (bus.ss) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    cnt_n   = cnt_q;
    hrs_n   = hrs_q;
    min_n   = min_q;
    sec_n   = sec_q;
    ahrs_n  = ahrs_q;
    amin_n  = amin_q;
    alarm_n = alarm_q;
    tick    = 1'b0;

    if (state == RUN) begin
      if (cnt_q == CNT_LAST) begin
        cnt_n = '0;
        tick  = 1'b1;
      end else begin
        cnt_n = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_n = '0;
    end

    // Only a running tick can match the alarm; edits and preloads never do.
    if (tick) begin
      sec_n = inc60(sec_q);
      if (sec_q == 6'd59) begin
        min_n = inc60(min_q);
        if (min_q == 6'd59) hrs_n = inc24(hrs_q);
      end
      if ((ALARM_EN != 0) && (hrs_n == ahrs_q) && (min_n == amin_q) && (sec_n == 6'd0))
        alarm_n = 1'b1;
    end

    case (state)
      PL: begin
        if (bus.load) begin
          case (bus.addr)
            3'd1: if (bus.din <= 6'd59) sec_n = bus.din;
            3'd2: if (bus.din <= 6'd59) min_n = bus.din;
            3'd3: if (bus.din[4:0] <= 5'd23) hrs_n = bus.din[4:0];
            3'd4: if (bus.din <= 6'd59) amin_n = bus.din;
            3'd5: if (bus.din[4:0] <= 5'd23) ahrs_n = bus.din[4:0];
            default: ;
          endcase
        end
      end
      HB: begin
        if (bus.inc)      hrs_n = inc24(hrs_q);
        else if (bus.dec) hrs_n = dec24(hrs_q);
      end
      MB: begin
        if (bus.inc)      min_n = inc60(min_q);
        else if (bus.dec) min_n = dec60(min_q);
      end
      SB: begin
        if (bus.inc)      sec_n = inc60(sec_q);
        else if (bus.dec) sec_n = dec60(sec_q);
      end
      AH: begin
        if (bus.inc)      ahrs_n = inc24(ahrs_q);
        else if (bus.dec) ahrs_n = dec24(ahrs_q);
      end
      AM: begin
        if (bus.inc)      amin_n = inc60(amin_q);
        else if (bus.dec) amin_n = dec60(amin_q);
      end
      default: ;
    endcase

    // Acknowledge beats a simultaneous match.
    if (bus.ss && alarm_q) alarm_n = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt_q   <= '0;
      hrs_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      ahrs_q  <= '0;
      amin_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt_q   <= cnt_n;
      hrs_q   <= hrs_n;
      min_q   <= min_n;
      sec_q   <= sec_n;
      ahrs_q  <= ahrs_n;
      amin_q  <= amin_n;
      alarm_q <= alarm_n;
    end
  end

  always_comb begin
    hrs_disp = hrs_q;
    if (bus.fmt12) begin
      if (hrs_q == 5'd0)      hrs_disp = 5'd12;
      else if (hrs_q > 5'd12) hrs_disp = hrs_q - 5'd12;
    end
  end

  assign bus.hrs   = hrs_disp;
  assign bus.pm    = bus.fmt12 && (hrs_q >= 5'd12);
  assign bus.min   = min_q;
  assign bus.sec   = sec_q;
  assign bus.alarm = (ALARM_EN != 0) ? alarm_q : 1'b0;
  assign bus.mode  = state;
endmodule

// File: tb/tb_hms_param_clock.sv
// Bench for hms_param_clock at TICK_DIV=5: table of single-edge vectors plus tick-run sequences,
// all expectations queued at drive time and popped after the following clock edge.
module tb_hms_param_clock;
  logic clk = 1'b0;
  logic rst = 1'b1;

  hms_param_clock_if bus();

  hms_param_clock #(.TICK_DIV(5), .ALARM_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         phase;
    string      name;
    logic       ss, sel, inc, dec, load;
    logic [2:0] addr;
    logic [5:0] din;
    logic       fmt12;
    logic [4:0] e_hrs;
    logic       e_pm;
    logic [5:0] e_min, e_sec;
    logic       e_alarm;
    logic [2:0] e_mode;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] hrs;
    logic       pm;
    logic [5:0] min, sec;
    logic       alarm;
    logic [2:0] mode;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(int ph, string n, int ss, int sel, int inc, int dec, int load,
                              int a, int d, int f, int h, int p, int m, int s, int al, int md);
    vec_t v;
    v.phase = ph;       v.name  = n;
    v.ss    = 1'(ss);   v.sel   = 1'(sel);  v.inc  = 1'(inc);  v.dec = 1'(dec);
    v.load  = 1'(load); v.addr  = 3'(a);    v.din  = 6'(d);    v.fmt12 = 1'(f);
    v.e_hrs = 5'(h);    v.e_pm  = 1'(p);    v.e_min = 6'(m);   v.e_sec = 6'(s);
    v.e_alarm = 1'(al); v.e_mode = 3'(md);
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic ss, sel, inc, dec, load, input logic [2:0] a,
                       input logic [5:0] d, input logic f);
    bus.ss = ss; bus.sel = sel; bus.inc = inc; bus.dec = dec;
    bus.load = load; bus.addr = a; bus.din = d; bus.fmt12 = f;
  endtask

  task automatic push_exp(input string n, input int h, p, m, s, al, md);
    exp_t e;
    e.name = n; e.hrs = 5'(h); e.pm = 1'(p); e.min = 6'(m); e.sec = 6'(s);
    e.alarm = 1'(al); e.mode = 3'(md);
    exp_q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    n_checks++;
    if ({bus.hrs, bus.pm, bus.min, bus.sec, bus.alarm, bus.mode} !==
        {e.hrs, e.pm, e.min, e.sec, e.alarm, e.mode}) begin
      n_fail++;
      $display("FAIL %s: got hrs=%0d pm=%0d min=%0d sec=%0d alarm=%0d mode=%0d, expected hrs=%0d pm=%0d min=%0d sec=%0d alarm=%0d mode=%0d",
               e.name, bus.hrs, bus.pm, bus.min, bus.sec, bus.alarm, bus.mode,
               e.hrs, e.pm, e.min, e.sec, e.alarm, e.mode);
    end
  endtask

  task automatic edge_and_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no queued expectation, expected one per edge");
    end else begin
      e = exp_q.pop_front();
      compare(e);
    end
  endtask

  task automatic check_now(input string n, input int h, p, m, s, al, md);
    push_exp(n, h, p, m, s, al, md);
    compare(exp_q.pop_front());
  endtask

  task automatic run_phase(input int ph);
    foreach (tbl[i]) begin
      if (tbl[i].phase == ph) begin
        drive(tbl[i].ss, tbl[i].sel, tbl[i].inc, tbl[i].dec, tbl[i].load,
              tbl[i].addr, tbl[i].din, tbl[i].fmt12);
        push_exp(tbl[i].name, tbl[i].e_hrs, tbl[i].e_pm, tbl[i].e_min, tbl[i].e_sec,
                 tbl[i].e_alarm, tbl[i].e_mode);
        edge_and_check();
      end
    end
  endtask

  task automatic idle_run(input string n, input int c, h, m, s, al);
    drive(0, 0, 0, 0, 0, 3'd0, 6'd0, 0);
    push_exp($sformatf("%s_c%0d", n, c), h, 0, m, s, al, 0);
    edge_and_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // ph, name, ss sel inc dec load addr din fmt12 | hrs pm min sec alarm mode
    add(1, "to_pl",      1,0,0,0,0, 0, 0,0,   0,0, 0, 2,0,1);
    add(1, "ld_sec60",   0,0,0,0,1, 1,60,0,   0,0, 0, 2,0,1);
    add(1, "ld_hrs24",   0,0,0,0,1, 3,24,0,   0,0, 0, 2,0,1);
    add(1, "ld_min59",   0,0,0,0,1, 2,59,0,   0,0,59, 2,0,1);
    add(1, "ld_hrs23",   0,0,0,0,1, 3,23,0,  23,0,59, 2,0,1);
    add(1, "ld_sec58",   0,0,0,0,1, 1,58,0,  23,0,59,58,0,1);
    add(1, "ld_addr7",   0,0,0,0,1, 7, 5,0,  23,0,59,58,0,1);
    add(1, "to_run",     1,0,0,0,0, 0, 0,0,  23,0,59,58,0,0);

    add(2, "fmt12_h0",   0,0,0,0,0, 0, 0,1,  12,0, 0, 1,1,0);
    add(2, "ss_clr",     1,0,0,0,0, 0, 0,0,   0,0, 0, 1,0,1);
    add(2, "pl_sel",     0,1,0,0,0, 0, 0,0,   0,0, 0, 1,0,2);
    add(2, "hb_dec",     0,0,0,1,0, 0, 0,0,  23,0, 0, 1,0,2);
    add(2, "hb_inc",     0,0,1,0,0, 0, 0,0,   0,0, 0, 1,0,2);
    add(2, "hb_sel",     0,1,0,0,0, 0, 0,0,   0,0, 0, 1,0,3);
    add(2, "mb_dec",     0,0,0,1,0, 0, 0,0,   0,0,59, 1,0,3);
    add(2, "mb_inc",     0,0,1,0,0, 0, 0,0,   0,0, 0, 1,0,3);
    add(2, "mb_incdec",  0,0,1,1,0, 0, 0,0,   0,0, 1, 1,0,3);
    add(2, "mb_dec2",    0,0,0,1,0, 0, 0,0,   0,0, 0, 1,0,3);
    add(2, "mb_selss",   1,1,0,0,0, 0, 0,0,   0,0, 0, 1,0,4);
    add(2, "sb_dec_noal",0,0,0,1,0, 0, 0,0,   0,0, 0, 0,0,4);
    add(2, "sb_dec_wrap",0,0,0,1,0, 0, 0,0,   0,0, 0,59,0,4);
    add(2, "sb_inc_wrap",0,0,1,0,0, 0, 0,0,   0,0, 0, 0,0,4);
    add(2, "sb_sel",     0,1,0,0,0, 0, 0,0,   0,0, 0, 0,0,5);
    add(2, "ah_sel",     0,1,0,0,0, 0, 0,0,   0,0, 0, 0,0,6);
    add(2, "am_inc",     0,0,1,0,0, 0, 0,0,   0,0, 0, 0,0,6);
    add(2, "am_sel",     0,1,0,0,0, 0, 0,0,   0,0, 0, 0,0,2);
    add(2, "hb_ss",      1,0,0,0,0, 0, 0,0,   0,0, 0, 0,0,0);
    add(2, "run_ss",     1,0,0,0,0, 0, 0,0,   0,0, 0, 0,0,1);
    add(2, "ld_sec59",   0,0,0,0,1, 1,59,0,   0,0, 0,59,0,1);
    add(2, "to_run2",    1,0,0,0,0, 0, 0,0,   0,0, 0,59,0,0);

    add(3, "sticky",     0,0,0,0,0, 0, 0,0,   0,0, 1, 0,1,0);
    add(3, "ss_clr2",    1,0,0,0,0, 0, 0,0,   0,0, 1, 0,0,1);
    add(3, "ld_ahrs7",   0,0,0,0,1, 5, 7,0,   0,0, 1, 0,0,1);
    add(3, "ld_amin0",   0,0,0,0,1, 4, 0,0,   0,0, 1, 0,0,1);
    add(3, "ld_hrs6",    0,0,0,0,1, 3, 6,0,   6,0, 1, 0,0,1);
    add(3, "ld_min59b",  0,0,0,0,1, 2,59,0,   6,0,59, 0,0,1);
    add(3, "ld_sec59b",  0,0,0,0,1, 1,59,0,   6,0,59,59,0,1);
    add(3, "to_run3",    1,0,0,0,0, 0, 0,0,   6,0,59,59,0,0);

    add(4, "ss_clr3",    1,0,0,0,0, 0, 0,0,   7,0, 0, 0,0,1);
    add(4, "f12_h0",     0,0,0,0,1, 3, 0,1,  12,0, 0, 0,0,1);
    add(4, "f12_h12",    0,0,0,0,1, 3,12,1,  12,1, 0, 0,0,1);
    add(4, "f12_h13",    0,0,0,0,1, 3,13,1,   1,1, 0, 0,0,1);
    add(4, "f12_h23",    0,0,0,0,1, 3,23,1,  11,1, 0, 0,0,1);
    add(4, "f24_h23",    0,0,0,0,0, 0, 0,0,  23,0, 0, 0,0,1);
    add(4, "pl_ss_sel",  1,1,0,0,0, 0, 0,0,  23,0, 0, 0,0,0);
    add(4, "run_sel",    0,1,0,0,0, 0, 0,0,  23,0, 0, 0,0,0);
    add(4, "run_load",   0,0,0,0,1, 1,30,0,  23,0, 0, 0,0,0);

    add(5, "to_pl5",     1,0,0,0,0, 0, 0,0,  23,0, 0, 0,0,1);
    add(5, "to_hb5",     0,1,0,0,0, 0, 0,0,  23,0, 0, 0,0,2);

    drive(0, 0, 0, 0, 0, 3'd0, 6'd0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", 0, 0, 0, 0, 0, 0);
    bus.fmt12 = 1'b1;
    #1;
    check_now("reset_fmt12", 12, 0, 0, 0, 0, 0);
    bus.fmt12 = 1'b0;
    rst = 1'b0;

    for (int c = 1; c <= 10; c++) idle_run("first_ticks", c, 0, 0, c / 5, 0);

    run_phase(1);
    for (int c = 1; c <= 15; c++) begin
      if (c < 5)       idle_run("rollover", c, 23, 59, 58, 0);
      else if (c < 10) idle_run("rollover", c, 23, 59, 59, 0);
      else if (c < 15) idle_run("rollover", c, 0, 0, 0, 1);
      else             idle_run("rollover", c, 0, 0, 1, 1);
    end

    run_phase(2);
    for (int c = 1; c <= 5; c++) begin
      if (c < 5) idle_run("alarm_edit", c, 0, 0, 59, 0);
      else       idle_run("alarm_edit", c, 0, 1, 0, 1);
    end

    run_phase(3);
    for (int c = 1; c <= 5; c++) begin
      if (c < 5) idle_run("alarm_0700", c, 6, 59, 59, 0);
      else       idle_run("alarm_0700", c, 7, 0, 0, 1);
    end

    run_phase(4);
    run_phase(5);

    rst = 1'b1;
    #1;
    check_now("rst_mid_edit", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) idle_run("post_rst", c, 0, 0, (c == 5) ? 1 : 0, 0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover expectations, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
